spike_event_fifo: RTL

Downstream stage of the leaky integrate-and-fire neuron. Captures every cycle on which the neuron's `spike` output is high as an event tagged with a free-running timestamp and the membrane `state` value from that cycle. Events are buffered in a small FIFO and presented on a valid/ready stream to the chip-level readout logic. Sits between the neuron and the output multiplexer so that readout back-pressure never stalls or alters the neuron.

---
 rtl/spike_event_fifo.sv | 93 +++++++++
 1 files changed

// File: rtl/spike_event_fifo.sv
// Event FIFO behind the LIF neuron: timestamps each spike cycle with the membrane value and buffers it for readout.
// Optional SPIKE_FIFO_DROP_CNT_EN adds a saturating 8-bit dropped-event counter on port drop_count.
module spike_event_fifo #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     spike,
   input  logic [7:0]               state,
   input  logic                     ts_en,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [TS_W-1:0]          ev_ts,
   output logic [7:0]               ev_state,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
`ifdef SPIKE_FIFO_DROP_CNT_EN
  ,output logic [7:0]               drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [TS_W-1:0]   ts;
   logic [TS_W+7:0]   mem [DEPTH];
   logic              empty;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop   = !empty && ev_ready;
   assign push  = spike && (!full || pop);
   assign drop  = spike && full && !pop;

   assign level    = wr_ptr - rd_ptr;
   assign ev_valid = !empty;

   always_comb begin
      ev_ts    = '0;
      ev_state = '0;
      if (!empty) begin
         {ev_ts, ev_state} = mem[rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts       <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (ts_en) begin
            ts <= ts + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage is deliberately left out of reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {ts, state};
      end
   end

`ifdef SPIKE_FIFO_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (drop && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end
`endif

endmodule
